// File: rtl/mvm_transpose_pkg.sv
// mvm_transpose_pkg
//   Definitions shared by the transposed matrix-vector multiplier and its
//   tile sub-module: FSM state encoding, a ceiling log2 helper, a ceiling
//   divide helper and the accumulator width expression (the same one the
//   forward mvm block uses).
package mvm_transpose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mvm_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // One extra bit above the worst-case sum of MATRIX_WIDTH products, so
    // the accumulator can never wrap.
    function automatic int acc_width(input int vcw, input int mcw, input int mw);
        return vcw + mcw + log2_ceil(mw) + 1;
    endfunction

endpackage

// File: rtl/mvm_t_tile.sv
// mvm_t_tile
//   Combinational TILING_ROW x TILING_COL signed multiply-accumulate tile.
//   Produces one partial sum per row lane; lanes disabled by row_mask or
//   col_mask contribute zero.
//   Ports:
//     vec_tile  TC vector cells, cell c at [c*VCW +: VCW]
//     mat_tile  TR*TC matrix cells, cell (r,c) at [(r*TC+c)*MCW +: MCW]
//     row_mask  1 = row lane maps to a real matrix row
//     col_mask  1 = column lane maps to a real matrix column
//     psum      TR signed partial sums, lane r at [r*ACC_W +: ACC_W]
module mvm_t_tile
    import mvm_transpose_pkg::*;
#(
    parameter int TR    = 3,
    parameter int TC    = 3,
    parameter int VCW   = 8,
    parameter int MCW   = 8,
    parameter int ACC_W = 19
) (
    input  logic [TC*VCW-1:0]    vec_tile,
    input  logic [TR*TC*MCW-1:0] mat_tile,
    input  logic [TR-1:0]        row_mask,
    input  logic [TC-1:0]        col_mask,
    output logic [TR*ACC_W-1:0]  psum
);

    localparam int PW  = VCW + MCW;
    localparam int EXT = ACC_W - PW;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] lane_sum;

    always_comb begin
        psum     = '0;
        prod     = '0;
        lane_sum = '0;
        for (int r = 0; r < TR; r++) begin
            lane_sum = '0;
            for (int c = 0; c < TC; c++) begin
                prod = $signed(mat_tile[(r*TC+c)*MCW +: MCW]) *
                       $signed(vec_tile[c*VCW +: VCW]);
                if (row_mask[r] && col_mask[c]) begin
                    lane_sum = lane_sum + {{EXT{prod[PW-1]}}, prod};
                end
            end
            psum[r*ACC_W +: ACC_W] = lane_sum;
        end
    end

endmodule

// File: rtl/mvm_transpose.sv
// mvm_transpose
//   Weights-transposed matrix-vector product for back-propagation:
//   result[h] = sat((sum_w matrix[h][w] * vector[w]) >>> FRACTION_WIDTH).
//   The matrix is walked in TILING_ROW x TILING_COL tiles, column tile
//   inner, row tile outer, one tile per CALC cycle.
//   Handshakes: a transfer happens on a rising edge where valid && ready
//   are both 1. Operand readies are only high in IDLE while that operand
//   is not yet held; result_valid is high exactly in DONE and the result
//   is released on the edge where result_ready is 1.
//   Ports:
//     clk, rst                      clock, asynchronous active-low reset
//     vector/_valid/_ready          input vector, cell w at [w*VCW +: VCW]
//     matrix/_valid/_ready          weights, cell (h,w) at [(h*W+w)*MCW +: MCW]
//     result/_valid/_ready          result, cell h at [h*RCW +: RCW]
//     error                         some cell saturated (with result_valid)
//     state_dbg                     current FSM state
module mvm_transpose
    import mvm_transpose_pkg::*;
#(
    parameter int MATRIX_WIDTH      = 4,
    parameter int MATRIX_HEIGHT     = 5,
    parameter int VECTOR_CELL_WIDTH = 8,
    parameter int MATRIX_CELL_WIDTH = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4,
    parameter int TILING_ROW        = 3,
    parameter int TILING_COL        = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]            vector,
    input  logic                                                 vector_valid,
    output logic                                                 vector_ready,
    input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0] matrix,
    input  logic                                                 matrix_valid,
    output logic                                                 matrix_ready,
    output logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]           result,
    output logic                                                 result_valid,
    input  logic                                                 result_ready,
    output logic                                                 error,
    output mvm_state_e                                           state_dbg
);

    localparam int W         = MATRIX_WIDTH;
    localparam int H         = MATRIX_HEIGHT;
    localparam int VCW       = VECTOR_CELL_WIDTH;
    localparam int MCW       = MATRIX_CELL_WIDTH;
    localparam int RCW       = RESULT_CELL_WIDTH;
    localparam int TR        = TILING_ROW;
    localparam int TC        = TILING_COL;
    localparam int ACC_W     = acc_width(VCW, MCW, W);
    localparam int ROW_TILES = ceil_div(H, TR);
    localparam int COL_TILES = ceil_div(W, TC);
    localparam int RT_W      = (ROW_TILES > 1) ? log2_ceil(ROW_TILES) : 1;
    localparam int CT_W      = (COL_TILES > 1) ? log2_ceil(COL_TILES) : 1;

    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((64'sd1 <<< (RCW - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(-(64'sd1 <<< (RCW - 1)));

    mvm_state_e state_q, state_d;

    logic                   vector_set, matrix_set;
    logic [W*VCW-1:0]       vec_buf;
    logic [H*W*MCW-1:0]     mat_buf;
    logic [RT_W-1:0]        row_t;
    logic [CT_W-1:0]        col_t;
    logic                   last_col, last_tile;

    logic [TC*VCW-1:0]      vec_tile;
    logic [TR*TC*MCW-1:0]   mat_tile;
    logic [TR-1:0]          row_mask;
    logic [TC-1:0]          col_mask;
    logic [TR*ACC_W-1:0]    psum;

    logic signed [ACC_W-1:0] acc      [H];
    logic signed [ACC_W-1:0] acc_sum  [H];
    logic signed [ACC_W-1:0] shifted  [H];
    logic [RCW-1:0]          sat_cell [H];
    logic [H-1:0]            row_hit, clamp;

    logic [H*RCW-1:0]        result_q;
    logic                    error_q;

    assign result    = result_q;
    assign error     = error_q;
    assign state_dbg = state_q;

    assign last_col  = (col_t == CT_W'(COL_TILES - 1));
    assign last_tile = last_col && (row_t == RT_W'(ROW_TILES - 1));

    // Gather the current tile's operands; lanes past the matrix edge stay 0.
    always_comb begin
        vec_tile = '0;
        mat_tile = '0;
        row_mask = '0;
        col_mask = '0;
        for (int c = 0; c < TC; c++) begin
            if (int'(col_t) * TC + c < W) begin
                col_mask[c] = 1'b1;
                vec_tile[c*VCW +: VCW] = vec_buf[(int'(col_t)*TC + c)*VCW +: VCW];
            end
        end
        for (int r = 0; r < TR; r++) begin
            if (int'(row_t) * TR + r < H) row_mask[r] = 1'b1;
        end
        for (int r = 0; r < TR; r++) begin
            for (int c = 0; c < TC; c++) begin
                if (row_mask[r] && col_mask[c]) begin
                    mat_tile[(r*TC + c)*MCW +: MCW] =
                        mat_buf[((int'(row_t)*TR + r)*W + int'(col_t)*TC + c)*MCW +: MCW];
                end
            end
        end
    end

    mvm_t_tile #(
        .TR    (TR),
        .TC    (TC),
        .VCW   (VCW),
        .MCW   (MCW),
        .ACC_W (ACC_W)
    ) u_tile (
        .vec_tile (vec_tile),
        .mat_tile (mat_tile),
        .row_mask (row_mask),
        .col_mask (col_mask),
        .psum     (psum)
    );

    // Per-row next accumulator value and its saturated, rescaled form. The
    // saturated value is only committed on the row tile's last column tile.
    always_comb begin : acc_update
        int lane;
        lane = 0;
        for (int h = 0; h < H; h++) begin
            row_hit[h]  = 1'b0;
            acc_sum[h]  = acc[h];
            clamp[h]    = 1'b0;
            lane        = h - int'(row_t) * TR;
            if (lane >= 0 && lane < TR) begin
                row_hit[h] = 1'b1;
                acc_sum[h] = acc[h] + $signed(psum[lane*ACC_W +: ACC_W]);
            end
            shifted[h] = acc_sum[h] >>> FRACTION_WIDTH;
            if (shifted[h] > RES_MAX) begin
                sat_cell[h] = RES_MAX[RCW-1:0];
                clamp[h]    = 1'b1;
            end else if (shifted[h] < RES_MIN) begin
                sat_cell[h] = RES_MIN[RCW-1:0];
                clamp[h]    = 1'b1;
            end else begin
                sat_cell[h] = shifted[h][RCW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        vector_ready = 1'b0;
        matrix_ready = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vector_ready = !vector_set;
                matrix_ready = !matrix_set;
                if (vector_set && matrix_set) state_d = ST_CALC;
            end
            ST_CALC: begin
                if (last_tile) state_d = ST_DONE;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vector_set <= 1'b0;
            matrix_set <= 1'b0;
            vec_buf    <= '0;
            mat_buf    <= '0;
            row_t      <= '0;
            col_t      <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            for (int h = 0; h < H; h++) acc[h] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vector_valid && vector_ready) begin
                        vec_buf    <= vector;
                        vector_set <= 1'b1;
                    end
                    if (matrix_valid && matrix_ready) begin
                        mat_buf    <= matrix;
                        matrix_set <= 1'b1;
                    end
                end
                ST_CALC: begin
                    for (int h = 0; h < H; h++) begin
                        if (row_hit[h]) begin
                            acc[h] <= acc_sum[h];
                            if (last_col) begin
                                result_q[h*RCW +: RCW] <= sat_cell[h];
                                if (clamp[h]) error_q <= 1'b1;
                            end
                        end
                    end
                    if (last_col) begin
                        col_t <= '0;
                        row_t <= last_tile ? '0 : row_t + 1'b1;
                    end else begin
                        col_t <= col_t + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        vector_set <= 1'b0;
                        matrix_set <= 1'b0;
                        result_q   <= '0;
                        error_q    <= 1'b0;
                        row_t      <= '0;
                        col_t      <= '0;
                        for (int h = 0; h < H; h++) acc[h] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_transpose.sv
module tb_mvm_transpose;
  import mvm_transpose_pkg::*;

  localparam int W   = 4;
  localparam int H   = 5;
  localparam int CW  = 8;
  localparam int FW  = 4;
  localparam int LAT = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W*CW-1:0]   vector;
  logic              vector_valid, vector_ready;
  logic [H*W*CW-1:0] matrix;
  logic              matrix_valid, matrix_ready;
  logic [H*CW-1:0]   result;
  logic              result_valid, result_ready;
  logic              error;
  mvm_state_e        state_dbg;

  mvm_transpose dut (
    .clk          (clk),
    .rst          (rst),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready),
    .matrix       (matrix),
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [H*CW-1:0] exp_q[$];
  logic            exp_err_q[$];
  logic [H*CW-1:0] last_exp;
  logic            last_err;

  // reference operands, as plain arrays
  logic [7:0] m_a [H][W];
  logic [7:0] v_a [W];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [H*W*CW-1:0] pack_m();
    logic [H*W*CW-1:0] p;
    p = '0;
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++)
        p[(h*W+w)*CW +: CW] = m_a[h][w];
    return p;
  endfunction

  function automatic logic [W*CW-1:0] pack_v();
    logic [W*CW-1:0] p;
    p = '0;
    for (int w = 0; w < W; w++) p[w*CW +: CW] = v_a[w];
    return p;
  endfunction

  task automatic fill_const(input logic [7:0] mv, input logic [7:0] vv);
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++) m_a[h][w] = mv;
    for (int w = 0; w < W; w++) v_a[w] = vv;
  endtask

  task automatic fill_rand();
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++) m_a[h][w] = 8'($urandom_range(0, 255));
    for (int w = 0; w < W; w++) v_a[w] = 8'($urandom_range(0, 255));
  endtask

  // Reference: exact integer dot product, floor shift, clamp to 8 bits.
  task automatic model_push();
    logic [H*CW-1:0] r;
    logic            e;
    longint          s;
    r = '0;
    e = 1'b0;
    for (int h = 0; h < H; h++) begin
      s = 0;
      for (int w = 0; w < W; w++)
        s += longint'($signed(m_a[h][w])) * longint'($signed(v_a[w]));
      s = s >>> FW;
      if (s > 127) begin
        s = 127;
        e = 1'b1;
      end else if (s < -128) begin
        s = -128;
        e = 1'b1;
      end
      r[h*CW +: CW] = s[7:0];
    end
    exp_q.push_back(r);
    exp_err_q.push_back(e);
  endtask

  // Count edges from the later capture edge until result_valid, then
  // compare against the scoreboard head.
  task automatic wait_result(input string tag);
    int k;
    k = 0;
    while (!result_valid && k < 40) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(LAT));
    last_exp = exp_q.pop_front();
    last_err = exp_err_q.pop_front();
    check({tag, "_result"}, 64'(result), 64'(last_exp));
    check({tag, "_error"}, 64'(error), 64'(last_err));
  endtask

  // Both operands offered together.
  task automatic run_op(input string tag);
    vector = pack_v();
    matrix = pack_m();
    vector_valid = 1'b1;
    matrix_valid = 1'b1;
    model_push();
    step();
    vector_valid = 1'b0;
    matrix_valid = 1'b0;
    check({tag, "_busy_readies"}, 64'({vector_ready, matrix_ready}), 64'(2'b00));
    wait_result(tag);
  endtask

  // Hold result_ready low for some cycles, then release the result.
  task automatic finish_op(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_result"}, 64'(result), 64'(last_exp));
      check({tag, "_hold_error"}, 64'(error), 64'(last_err));
      check({tag, "_hold_valid"}, 64'(result_valid), 64'(1));
      check({tag, "_hold_readies"}, 64'({vector_ready, matrix_ready}), 64'(2'b00));
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(result_valid), 64'(0));
    check({tag, "_post_readies"}, 64'({vector_ready, matrix_ready}), 64'(2'b11));
    check({tag, "_post_result"}, 64'(result), 64'(0));
    check({tag, "_post_error"}, 64'(error), 64'(0));
  endtask

  initial begin
    logic [H*W*CW-1:0] m_second;

    vector       = '0;
    matrix       = '0;
    vector_valid = 1'b0;
    matrix_valid = 1'b0;
    result_ready = 1'b0;

    // reset state
    rst = 1'b0;
    #1;
    check("rst_result", 64'(result), 64'(0));
    check("rst_valid", 64'(result_valid), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_readies", 64'({vector_ready, matrix_ready}), 64'(2'b11));
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    step();
    step();
    rst = 1'b1;
    step();

    // 1.0 * 1.0 over 4 columns -> 4.0
    fill_const(8'h10, 8'h10);
    run_op("unit");
    check("unit_const", 64'(result), 64'({5{8'h40}}));
    finish_op("unit", 0);

    // 2.0 * -1.0 over 4 columns -> exactly -8.0, no clamp
    fill_const(8'h20, 8'hF0);
    run_op("neg8");
    check("neg8_const", 64'(result), 64'({5{8'h80}}));
    finish_op("neg8", 1);

    // positive overflow, with result_ready held low for 5 cycles; a new
    // vector offered meanwhile must wait for IDLE
    fill_const(8'h70, 8'h70);
    run_op("satp");
    check("satp_const", 64'(result), 64'({5{8'h7F}}));
    v_a = '{8'h90, 8'h90, 8'h90, 8'h90};
    vector = pack_v();
    vector_valid = 1'b1;
    finish_op("satp", 5);
    step();
    vector_valid = 1'b0;
    check("late_vec_ready", 64'({vector_ready, matrix_ready}), 64'(2'b01));
    matrix_valid = 1'b1;
    model_push();
    step();
    matrix_valid = 1'b0;
    wait_result("satn");
    check("satn_const", 64'(result), 64'({5{8'h80}}));
    finish_op("satn", 0);

    // matrix first, a second matrix offered while the first is held
    fill_rand();
    matrix = pack_m();
    matrix_valid = 1'b1;
    step();
    m_second = ~matrix;
    matrix = m_second;
    check("mfirst_readies_1", 64'({vector_ready, matrix_ready}), 64'(2'b10));
    step();
    check("mfirst_readies_2", 64'({vector_ready, matrix_ready}), 64'(2'b10));
    step();
    matrix_valid = 1'b0;
    vector = pack_v();
    vector_valid = 1'b1;
    model_push();
    step();
    vector_valid = 1'b0;
    wait_result("mfirst");
    finish_op("mfirst", 0);

    // reset during the second CALC cycle discards the operation
    fill_rand();
    vector = pack_v();
    matrix = pack_m();
    vector_valid = 1'b1;
    matrix_valid = 1'b1;
    step();
    vector_valid = 1'b0;
    matrix_valid = 1'b0;
    step();
    step();
    check("abort_in_calc", 64'(state_dbg), 64'(ST_CALC));
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid", 64'(result_valid), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    check("abort_readies", 64'({vector_ready, matrix_ready}), 64'(2'b11));
    check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
    step();
    rst = 1'b1;
    step();
    check("abort_still_idle", 64'(result_valid), 64'(0));

    // identity rows after the aborted run
    fill_const(8'h00, 8'h00);
    for (int h = 0; h < W; h++) m_a[h][h] = 8'h10;
    v_a = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_op("ident");
    check("ident_const", 64'(result), 64'(40'h00_40_30_20_10));
    finish_op("ident", 0);

    // randomized operands
    for (int i = 0; i < 10; i++) begin
      fill_rand();
      run_op("rand");
      finish_op("rand", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
